// File: rtl/mantissa_pkg.sv
// Shared widths and payload type for the FP adder mantissa add/sub + normalize stage.
package mantissa_pkg;
    localparam int SIZE_DATA  = 28;
    localparam int SIZE_EXP   = 8;
    localparam int HIDDEN_BIT = 26;
    localparam int CARRY_BIT  = 27;
    localparam int EXP_MAX    = (1 << SIZE_EXP) - 1;
    localparam int LZC_W      = 5;

    typedef struct packed {
        logic                 sign;
        logic [SIZE_EXP-1:0]  exponent;
        logic [SIZE_DATA-1:0] mantissa;
    } payload_t;
endpackage

// File: rtl/mantissa_lzc.sv
// Combinational leading-zero counter over the hidden bit and everything below it.
module mantissa_lzc
    import mantissa_pkg::*;
(
    input  logic [HIDDEN_BIT:0] i_data,
    output logic [LZC_W-1:0]    o_count,
    output logic                o_all_zero
);

    // NOTE: default first, then override -- a combinational block that leaves
    // any path unassigned infers a latch.
    always_comb begin
        o_count = LZC_W'(HIDDEN_BIT + 1);
        for (int i = 0; i <= HIDDEN_BIT; i++) begin
            if (i_data[i]) begin
                o_count = LZC_W'(HIDDEN_BIT - i);
            end
        end
    end

    assign o_all_zero = ~|i_data;

endmodule

// File: rtl/mantissa_addsub_norm.sv
// Effective add/subtract of the ordered mantissa pair, then normalization,
// delivered through a two-stage valid/ready pipeline.
module mantissa_addsub_norm
    import mantissa_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_sign_greater,
    input  logic [SIZE_DATA-1:0] i_mantissa_greater,
    input  logic                 i_sign_less,
    input  logic [SIZE_DATA-1:0] i_mantissa_less,
    input  logic [SIZE_EXP-1:0]  i_exponent,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_sign,
    output logic [SIZE_EXP-1:0]  o_exponent,
    output logic [SIZE_DATA-1:0] o_mantissa,
    output logic                 o_zero,
    output logic                 o_overflow
);

    localparam logic [SIZE_EXP:0]   EXP_MAX_X = (SIZE_EXP + 1)'(EXP_MAX);
    localparam logic [SIZE_EXP-1:0] EXP_SAT   = SIZE_EXP'(EXP_MAX);

    logic     s1_valid_d, s1_valid_q;
    payload_t s1_d, s1_q;
    logic     s2_valid_d, s2_valid_q;
    payload_t s2_d, s2_q;
    logic     zero_d, zero_q;
    logic     overflow_d, overflow_q;
    logic     s2_free;

    assign s2_free = !s2_valid_q || i_ready;
    assign o_ready = !s1_valid_q || s2_free;

    // Stage 1: effective add/sub; greater >= less so subtraction never wraps.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (o_ready) begin
            s1_valid_d = i_valid;
            if (i_valid) begin
                s1_d.sign     = i_sign_greater;
                s1_d.exponent = i_exponent;
                s1_d.mantissa = (i_sign_greater ^ i_sign_less)
                              ? i_mantissa_greater - i_mantissa_less
                              : i_mantissa_greater + i_mantissa_less;
            end
        end
    end

    logic [LZC_W-1:0]     lzc;
    logic                 lzc_zero;
    logic [SIZE_EXP:0]    exp_ext, exp_inc, exp_dec, exp_sub;
    logic [LZC_W-1:0]     shift;
    payload_t             norm;
    logic                 norm_zero, norm_overflow;

    mantissa_lzc u_lzc (
        .i_data     (s1_q.mantissa[HIDDEN_BIT:0]),
        .o_count    (lzc),
        .o_all_zero (lzc_zero)
    );

    assign exp_ext = {1'b0, s1_q.exponent};
    assign exp_inc = exp_ext + 1'b1;
    assign exp_dec = exp_ext - 1'b1;
    assign exp_sub = exp_ext - {{(SIZE_EXP + 1 - LZC_W){1'b0}}, lzc};

    // Stage 2: carry shift-right, exact zero, or left shift clamped so the
    // exponent never goes below 1 (anything further is a subnormal at exp 0).
    always_comb begin
        norm          = '0;
        norm.sign     = s1_q.sign;
        norm_zero     = 1'b0;
        norm_overflow = 1'b0;
        shift         = '0;
        if (s1_q.mantissa[CARRY_BIT]) begin
            if (exp_inc >= EXP_MAX_X) begin
                norm_overflow = 1'b1;
                norm.exponent = EXP_SAT;
            end else begin
                norm.exponent = exp_inc[SIZE_EXP-1:0];
                norm.mantissa = {1'b0, s1_q.mantissa[SIZE_DATA-1:2],
                                 s1_q.mantissa[1] | s1_q.mantissa[0]};
            end
        end else if (lzc_zero) begin
            norm_zero = 1'b1;
            norm.sign = 1'b0;
        end else begin
            if (exp_ext == '0) begin
                norm.exponent = '0;
            end else if ({{(SIZE_EXP + 1 - LZC_W){1'b0}}, lzc} <= exp_dec) begin
                shift         = lzc;
                norm.exponent = exp_sub[SIZE_EXP-1:0];
            end else begin
                shift         = exp_dec[LZC_W-1:0];
                norm.exponent = '0;
            end
            norm.mantissa = s1_q.mantissa << shift;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        zero_d     = zero_q;
        overflow_d = overflow_q;
        if (s2_free) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_d       = norm;
                zero_d     = norm_zero;
                overflow_d = norm_overflow;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            s2_q       <= s2_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_valid    = s2_valid_q;
    assign o_sign     = s2_q.sign;
    assign o_exponent = s2_q.exponent;
    assign o_mantissa = s2_q.mantissa;
    assign o_zero     = zero_q;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_mantissa_addsub_norm.sv
// Scoreboard bench: driver pushes hand-computed results, monitor pops on each output transfer.
module tb_mantissa_addsub_norm;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [27:0] mantissa;
        logic        zero;
        logic        overflow;
    } res_t;

    typedef struct packed {
        logic        sg;
        logic [27:0] mg;
        logic        sl;
        logic [27:0] ml;
        logic [7:0]  e;
        res_t        res;
    } vec_t;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic        i_sign_greater;
    logic [27:0] i_mantissa_greater;
    logic        i_sign_less;
    logic [27:0] i_mantissa_less;
    logic [7:0]  i_exponent;
    logic        o_valid;
    logic        i_ready;
    logic        o_sign;
    logic [7:0]  o_exponent;
    logic [27:0] o_mantissa;
    logic        o_zero;
    logic        o_overflow;

    int   n_checks = 0;
    int   n_errors = 0;
    res_t exp_q[$];

    mantissa_addsub_norm dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_valid            (i_valid),
        .o_ready            (o_ready),
        .i_sign_greater     (i_sign_greater),
        .i_mantissa_greater (i_mantissa_greater),
        .i_sign_less        (i_sign_less),
        .i_mantissa_less    (i_mantissa_less),
        .i_exponent         (i_exponent),
        .o_valid            (o_valid),
        .i_ready            (i_ready),
        .o_sign             (o_sign),
        .o_exponent         (o_exponent),
        .o_mantissa         (o_mantissa),
        .o_zero             (o_zero),
        .o_overflow         (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic vec_t mk(input logic sg, input logic [27:0] mg, input logic sl,
                                input logic [27:0] ml, input logic [7:0] e,
                                input logic rs, input logic [7:0] re, input logic [27:0] rm,
                                input logic rz, input logic ro);
        vec_t v;
        v.sg = sg; v.mg = mg; v.sl = sl; v.ml = ml; v.e = e;
        v.res = '{sign: rs, exponent: re, mantissa: rm, zero: rz, overflow: ro};
        return v;
    endfunction

    task automatic send(input vec_t v);
        int n;
        n = 0;
        @(negedge i_clk);
        i_valid            = 1'b1;
        i_sign_greater     = v.sg;
        i_mantissa_greater = v.mg;
        i_sign_less        = v.sl;
        i_mantissa_less    = v.ml;
        i_exponent         = v.e;
        #1;
        while (!o_ready && n < 50) begin
            @(negedge i_clk);
            #1;
            n++;
        end
        if (!o_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: o_ready stuck at 0 for %0d cycles, required 1", n);
            i_valid = 1'b0;
        end else begin
            exp_q.push_back(v.res);
        end
        @(posedge i_clk);
    endtask

    task automatic idle();
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge i_clk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: compare on every output transfer; also require held outputs during stalls.
    initial begin
        res_t cur;
        res_t held;
        bit   stall_prev;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge i_clk);
            #2;
            cur = '{sign: o_sign, exponent: o_exponent, mantissa: o_mantissa,
                    zero: o_zero, overflow: o_overflow};
            if (stall_prev && o_valid) check("hold_stable", 64'(cur), 64'(held));
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL spurious_output: got %h with nothing expected", cur);
                end else begin
                    check("result", 64'(cur), 64'(exp_q.pop_front()));
                end
            end
            stall_prev = o_valid && !i_ready;
            held = cur;
        end
    end

    vec_t v_add11, v_sub, v_cancel, v_ovf, v_254, v_sticky, v_norm, v_subn, v_exp0, v_edge, v_grs;

    initial begin
        v_add11  = mk(0, 28'h400_0000, 0, 28'h400_0000, 8'd127, 0, 8'd128, 28'h400_0000, 0, 0);
        v_sub    = mk(0, 28'h400_0000, 1, 28'h200_0000, 8'd127, 0, 8'd126, 28'h400_0000, 0, 0);
        v_cancel = mk(1, 28'h4A0_0008, 0, 28'h4A0_0008, 8'd90,  0, 8'd0,   28'h000_0000, 1, 0);
        v_ovf    = mk(0, 28'h600_0000, 0, 28'h600_0000, 8'd254, 0, 8'd255, 28'h000_0000, 0, 1);
        v_254    = mk(0, 28'h400_0000, 0, 28'h400_0000, 8'd253, 0, 8'd254, 28'h400_0000, 0, 0);
        v_sticky = mk(1, 28'h400_0003, 1, 28'h400_0000, 8'd10,  1, 8'd11,  28'h400_0001, 0, 0);
        v_norm   = mk(0, 28'h0C0_0000, 1, 28'h040_0000, 8'd100, 0, 8'd97,  28'h400_0000, 0, 0);
        v_subn   = mk(0, 28'h040_0000, 0, 28'h000_0000, 8'd3,   0, 8'd0,   28'h100_0000, 0, 0);
        v_exp0   = mk(1, 28'h100_0000, 1, 28'h000_0000, 8'd0,   1, 8'd0,   28'h100_0000, 0, 0);
        v_edge   = mk(0, 28'h080_0000, 0, 28'h000_0000, 8'd4,   0, 8'd1,   28'h400_0000, 0, 0);
        v_grs    = mk(0, 28'h400_0000, 1, 28'h000_0001, 8'd50,  0, 8'd49,  28'h7FF_FFFE, 0, 0);

        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        i_sign_greater = 1'b0; i_mantissa_greater = '0;
        i_sign_less = 1'b0; i_mantissa_less = '0; i_exponent = '0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check("reset_o_valid", 64'(o_valid), 64'd0);
        check("reset_o_ready", 64'(o_ready), 64'd1);
        check("reset_outputs", 64'({o_sign, o_exponent, o_mantissa, o_zero, o_overflow}), 64'd0);

        // Directed vectors back to back with i_ready high.
        send(v_add11); send(v_sub); send(v_cancel); send(v_ovf); send(v_254); send(v_sticky);
        send(v_norm); send(v_subn); send(v_exp0); send(v_edge); send(v_grs);
        idle();
        drain();

        // Backpressure: i_ready low for four cycles while four items stream in.
        fork
            begin
                send(v_add11); send(v_sub); send(v_norm); send(v_sticky);
                idle();
            end
            begin
                @(negedge i_clk);
                @(negedge i_clk);
                i_ready = 1'b0;
                @(negedge i_clk);
                #1;
                check("bp_o_ready_low", 64'(o_ready), 64'd0);
                check("bp_o_valid_high", 64'(o_valid), 64'd1);
                repeat (3) @(negedge i_clk);
                i_ready = 1'b1;
            end
        join
        drain();

        // Reset with both stages full; in-flight items are discarded.
        @(negedge i_clk);
        i_ready = 1'b0;
        send(v_ovf); send(v_cancel);
        idle();
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_o_valid", 64'(o_valid), 64'd0);
        check("midrst_o_ready", 64'(o_ready), 64'd1);
        check("midrst_outputs", 64'({o_sign, o_exponent, o_mantissa, o_zero, o_overflow}), 64'd0);
        i_ready = 1'b1;
        send(v_sub);
        idle();
        drain();

        repeat (3) @(negedge i_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
